muldiv_sequencer: RTL and testbench

Sequences the shared multiplier and divider for the multicycle CPU. It accepts one MULT or DIV request from the control unit, latches the operands, and pulses the start of the selected unit. It then waits for that unit's ready and drives the single HI/LO write port with the result. It also screens divide-by-zero before the divider is started and aborts any operation whose ready never arrives.

---
 rtl/muldiv_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared multiplier and divider for the multicycle CPU.
// Latency: 4 cycles from request to IDLE when ready returns in the first RUN cycle
//   (START, RUN, WB, then IDLE). Longer if the unit is slow; aborts after TIMEOUT_CYCLES RUN cycles.
// Backpressure: none. Requests are sampled only in IDLE. Requests that arrive while busy are
//   dropped, not queued. The control unit waits for done, div_zero_exc or timeout_err.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_mult, req_div          one-cycle-sampled requests (MULT has priority)
//   op_a, op_b                 operands, latched into unit_a/unit_b on acceptance
//   unit_a, unit_b             stable operands to the arithmetic units
//   mult_start, div_start      one-cycle start pulses
//   mult_ready/hi/lo           multiplier result handshake
//   div_ready/hi/lo            divider result handshake (hi = remainder, lo = quotient)
//   hi_out, lo_out, hi_wr, lo_wr   HI/LO write port; data persists between operations
//   busy, done                 status; done pulses together with the HI/LO write
//   div_zero_exc, timeout_err  one-cycle error pulses

module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_mult,
  input  logic        req_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_ready,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_ready,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        hi_wr,
  output logic        lo_wr,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_M = 3'd1,
    START_D = 3'd2,
    RUN_M   = 3'd3,
    RUN_D   = 3'd4,
    WB      = 3'd5,
    EXC     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Only the unit selected by the current RUN state is observed; the
  // other unit's handshake is ignored entirely.
  logic             run_ready;
  logic [31:0]      run_hi;
  logic [31:0]      run_lo;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    run_ready = 1'b0;
    run_hi    = 32'd0;
    run_lo    = 32'd0;
    if (state == RUN_M) begin
      run_ready = mult_ready;
      run_hi    = mult_hi;
      run_lo    = mult_lo;
    end else if (state == RUN_D) begin
      run_ready = div_ready;
      run_hi    = div_hi;
      run_lo    = div_lo;
    end
  end

  // Saturating increment: the counter must never wrap back below the limit.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CNT_MAX) begin
      cnt_inc = cnt + 1'b1;
    end
  end

  // Every output is a register written alongside the state transition, so
  // each pulse lines up with the state it belongs to (mult_start during
  // START_M, done during WB, and so on).
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      unit_a       <= 32'd0;
      unit_b       <= 32'd0;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_out       <= 32'd0;
      lo_out       <= 32'd0;
      hi_wr        <= 1'b0;
      lo_wr        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      hi_wr        <= 1'b0;
      lo_wr        <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (req_mult) begin
            // MULT has priority; a simultaneous DIV request is dropped.
            unit_a     <= op_a;
            unit_b     <= op_b;
            mult_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START_M;
          end else if (req_div) begin
            if (op_b != 32'd0) begin
              unit_a    <= op_a;
              unit_b    <= op_b;
              div_start <= 1'b1;
              busy      <= 1'b1;
              state     <= START_D;
            end else begin
              // Divide-by-zero is screened here so the divider never starts.
              div_zero_exc <= 1'b1;
              busy         <= 1'b1;
              state        <= EXC;
            end
          end
        end

        START_M: begin
          cnt   <= '0;
          state <= RUN_M;
        end

        START_D: begin
          cnt   <= '0;
          state <= RUN_D;
        end

        RUN_M, RUN_D: begin
          if (run_ready) begin
            // A ready on the same edge as the timeout still completes.
            hi_out <= run_hi;
            lo_out <= run_lo;
            hi_wr  <= 1'b1;
            lo_wr  <= 1'b1;
            done   <= 1'b1;
            state  <= WB;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= CNT_LIMIT) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end

        WB: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        EXC: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_mult, req_div;
  logic [31:0] op_a, op_b;
  logic [31:0] unit_a, unit_b;
  logic        mult_start, div_start;
  logic        mult_ready, div_ready;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [31:0] hi_out, lo_out;
  logic        hi_wr, lo_wr, busy, done, div_zero_exc, timeout_err;

  int errors = 0;
  int checks = 0;

  // Transaction-level model state: the last value written to HI/LO.
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req_mult(req_mult), .req_div(req_div),
    .op_a(op_a), .op_b(op_b),
    .unit_a(unit_a), .unit_b(unit_b),
    .mult_start(mult_start), .div_start(div_start),
    .mult_ready(mult_ready), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_ready(div_ready), .div_hi(div_hi), .div_lo(div_lo),
    .hi_out(hi_out), .lo_out(lo_out), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".unit_a"}, unit_a, 32'd0);
    chk({tag, ".unit_b"}, unit_b, 32'd0);
    chk({tag, ".hi_out"}, hi_out, 32'd0);
    chk({tag, ".lo_out"}, lo_out, 32'd0);
    chk({tag, ".pulses"}, 32'({mult_start, div_start, hi_wr, lo_wr, done, div_zero_exc, timeout_err}), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // One complete operation. lat = RUN cycle (1-based) in which the selected
  // unit raises ready; lat outside 1..TO means the unit never answers in time.
  task automatic do_op(input string tag, input bit rm, input bit rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] rh, input logic [31:0] rl);
    bit is_m, is_exc, wrote;
    is_m   = rm;
    is_exc = !rm && rd && (b == 32'd0);
    wrote  = 1'b0;

    req_mult = rm; req_div = rd; op_a = a; op_b = b;
    tick();
    req_mult = 1'b0; req_div = 1'b0;

    if (is_exc) begin
      chk({tag, ".exc"},       32'(div_zero_exc), 32'd1);
      chk({tag, ".exc_busy"},  32'(busy), 32'd1);
      chk({tag, ".exc_start"}, 32'({mult_start, div_start}), 32'd0);
      chk({tag, ".exc_wr"},    32'({hi_wr, lo_wr, done}), 32'd0);
      tick();
      chk({tag, ".exc_end"},   32'({div_zero_exc, busy}), 32'd0);
      return;
    end

    chk({tag, ".start"},  32'({mult_start, div_start}), is_m ? 32'd2 : 32'd1);
    chk({tag, ".busy0"},  32'(busy), 32'd1);
    chk({tag, ".unit_a"}, unit_a, a);
    chk({tag, ".unit_b"}, unit_b, b);
    chk({tag, ".noexc"},  32'(div_zero_exc), 32'd0);

    for (int r = 1; r <= TO; r++) begin
      tick();
      chk({tag, ".run"}, 32'({mult_start, div_start, hi_wr, done, div_zero_exc, timeout_err, busy}), 32'd1);
      chk({tag, ".hold_a"}, unit_a, a);
      // Noise that must be ignored while busy: new requests, operand changes,
      // and the unselected unit's handshake with junk data.
      op_a = $urandom; op_b = $urandom;
      req_mult = 1'($urandom_range(0, 1));
      req_div  = 1'($urandom_range(0, 1));
      if (is_m) begin
        div_ready = 1'($urandom_range(0, 1)); div_hi = $urandom; div_lo = $urandom;
      end else begin
        mult_ready = 1'($urandom_range(0, 1)); mult_hi = $urandom; mult_lo = $urandom;
      end
      if (r == lat) begin
        wrote = 1'b1;
        if (is_m) begin mult_ready = 1'b1; mult_hi = rh; mult_lo = rl; end
        else      begin div_ready  = 1'b1; div_hi  = rh; div_lo  = rl; end
      end else begin
        if (is_m) mult_ready = 1'b0; else div_ready = 1'b0;
      end
      if (wrote) break;
    end

    tick();
    req_mult = 1'b0; req_div = 1'b0; mult_ready = 1'b0; div_ready = 1'b0;

    if (wrote) begin
      model_hi = rh; model_lo = rl;
      chk({tag, ".wb_strobes"}, 32'({hi_wr, lo_wr, done, busy}), 32'hF);
      chk({tag, ".wb_hi"}, hi_out, model_hi);
      chk({tag, ".wb_lo"}, lo_out, model_lo);
      chk({tag, ".wb_to"}, 32'(timeout_err), 32'd0);
      tick();
      chk({tag, ".idle"}, 32'({hi_wr, lo_wr, done, busy}), 32'd0);
    end else begin
      chk({tag, ".timeout"},   32'(timeout_err), 32'd1);
      chk({tag, ".to_nowr"},   32'({hi_wr, lo_wr, done, busy}), 32'd0);
      tick();
      chk({tag, ".to_pulse"},  32'(timeout_err), 32'd0);
    end
    chk({tag, ".keep_hi"}, hi_out, model_hi);
    chk({tag, ".keep_lo"}, lo_out, model_lo);
  endtask

  initial begin
    logic [63:0] prod;
    logic [31:0] a, b;
    bit rm, rd;
    int lat;

    reset = 1'b1; req_mult = 1'b0; req_div = 1'b0; op_a = 32'd0; op_b = 32'd0;
    mult_ready = 1'b0; div_ready = 1'b0;
    mult_hi = 32'd0; mult_lo = 32'd0; div_hi = 32'd0; div_lo = 32'd0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Directed steps.
    do_op("mult_neg",  1, 0, 32'd7,   32'hFFFF_FFFD, 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("div_100_7", 0, 1, 32'd100, 32'd7,          3,  32'd2,         32'd14);
    do_op("div_zero",  0, 1, 32'd55,  32'd0,          1,  32'd0,         32'd0);
    do_op("mult_to",   1, 0, 32'd3,   32'd4,          0,  32'd0,         32'd0);
    do_op("mult_min",  1, 0, 32'd3,   32'd4,          1,  32'd0,         32'd12);
    do_op("both_req",  1, 1, 32'd9,   32'd0,          5,  32'd0,         32'd0);
    do_op("ready_last",0, 1, 32'd50,  32'd5,          TO, 32'd0,         32'd10);
    do_op("div_to",    0, 1, 32'd50,  32'd5,          TO + 1, 32'd0,     32'd10);

    // Reset in the middle of a divide: nothing written, late ready ignored.
    req_div = 1'b1; op_a = 32'd9; op_b = 32'd3;
    tick();
    req_div = 1'b0;
    tick(); tick();
    chk("rst_mid.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rst_mid");
    div_ready = 1'b1; div_hi = 32'h0BAD; div_lo = 32'h0BAD;
    tick();
    div_ready = 1'b0;
    chk("rst_late.nowr", 32'({hi_wr, lo_wr, done, busy}), 32'd0);
    chk("rst_late.hi", hi_out, 32'd0);
    model_hi = 32'd0; model_lo = 32'd0;

    // Randomized operations against the transaction model.
    for (int n = 0; n < 24; n++) begin
      rm = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!rm && !rd) rd = 1'b1;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      lat = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
      if (rm) begin
        prod = {32'd0, a} * {32'd0, b};
        do_op("rnd_mult", 1, rd, a, b, lat, prod[63:32], prod[31:0]);
      end else if (b != 32'd0) begin
        do_op("rnd_div", 0, 1, a, b, lat, a % b, a / b);
      end else begin
        do_op("rnd_dz", 0, 1, a, b, lat, 32'd0, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
